// File: rtl/dump_pkg.sv
// Shared state encoding, character constants and ASCII helpers for the memory hex dumper.
package dump_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_NL,
        ST_ADDR,
        ST_COLON,
        ST_FETCH,
        ST_WAIT,
        ST_GSP,
        ST_HEXH,
        ST_HEXL,
        ST_ASP,
        ST_AFETCH,
        ST_AWAIT,
        ST_ACHR,
        ST_NEXT,
        ST_DONE
    } hexdump_st_e;

    localparam logic [7:0] CH_NL    = 8'h0a;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3a;
    localparam logic [7:0] CH_DOT   = 8'h2e;

    // 0x57 is 'a' minus ten, so nibbles 10..15 land on 'a'..'f'.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] printable(input logic [7:0] b);
        return (b >= 8'h20 && b <= 8'h7e) ? b : CH_DOT;
    endfunction

endpackage

// File: rtl/hexdump_fmt.sv
// Output character mux: picks the ASCII char for the current state from the row
// address digit index or the byte register.
module hexdump_fmt
    import dump_pkg::*;
#(
    parameter int ASZ = 17,
    parameter int ADW = (ASZ + 3) / 4,
    parameter int DW  = 3
) (
    input  logic [3:0]     state_i,
    input  logic [ASZ-1:0] row_a_i,
    input  logic [DW-1:0]  didx_i,
    input  logic [7:0]     byte_i,
    output logic [7:0]     tx_data_o
);

    hexdump_st_e        st;
    logic [4*ADW-1:0]   ra_ext;
    logic [3:0]         nib;

    assign st     = hexdump_st_e'(state_i);
    assign ra_ext = (4*ADW)'(row_a_i);

    // Digit 0 is the most significant nibble of the zero-extended row address.
    always_comb begin
        nib = 4'h0;
        for (int k = 0; k < ADW; k++) begin
            if (int'(didx_i) == k) nib = ra_ext[4*(ADW-1-k) +: 4];
        end
    end

    always_comb begin
        tx_data_o = 8'h00;
        case (st)
            ST_NL:    tx_data_o = CH_NL;
            ST_ADDR:  tx_data_o = hex_char(nib);
            ST_COLON: tx_data_o = CH_COLON;
            ST_GSP:   tx_data_o = CH_SP;
            ST_HEXH:  tx_data_o = hex_char(byte_i[7:4]);
            ST_HEXL:  tx_data_o = hex_char(byte_i[3:0]);
`ifdef MEM_HEXDUMP_ASCII_EN
            ST_ASP:   tx_data_o = CH_SP;
            ST_ACHR:  tx_data_o = printable(byte_i);
`endif
            default:  tx_data_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/mem_hexdump.sv
// Walks a byte range of the 8-bit memory and streams a formatted hex dump.
// Define MEM_HEXDUMP_ASCII_EN to append an ASCII column to each row.
module mem_hexdump
    import dump_pkg::*;
#(
    parameter int ASZ = 17,
    parameter int ROW = 16,
    parameter int GRP = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [ASZ-1:0] addr,
    input  logic [ASZ-1:0] len,
    output logic           busy,
    output logic           done,
    output logic [ASZ-1:0] mem_a,
    output logic           mem_rd,
    input  logic [7:0]     mem_vo,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic [7:0]     tx_data,
    output logic [3:0]     dbg_state_o
);

    localparam int ADW = (ASZ + 3) / 4;
    localparam int RB  = $clog2(ROW);
    localparam int RCW = ASZ - RB + 1;
    localparam int DW  = $clog2(ADW + 1);

    hexdump_st_e    state_q, state_d;
    logic [ASZ-1:0] row_q, row_d;
    logic [RCW-1:0] rows_q, rows_d;
    logic [RB-1:0]  bidx_q, bidx_d;
    logic [DW-1:0]  didx_q, didx_d;
    logic [7:0]     byte_q, byte_d;

    logic [ASZ:0]   span;
    logic [RCW-1:0] nrows;
    logic [ASZ-1:0] byte_a;
    logic           grp_start;

    // Offset into the first row plus length, rounded up to whole rows.
    assign span      = (ASZ+1)'(addr[RB-1:0]) + (ASZ+1)'(len) + (ASZ+1)'(ROW - 1);
    assign nrows     = RCW'(span >> RB);
    assign byte_a    = {row_q[ASZ-1:RB], bidx_q};
    assign grp_start = (int'(bidx_q) % GRP) == 0;

    // tx handshake: a char moves on a cycle with tx_valid and tx_ready both high;
    // while tx_valid is high and tx_ready low, state (hence tx_data) holds, so
    // tx_valid only drops after a transfer.
    always_comb begin
        tx_valid = 1'b0;
        case (state_q)
            ST_NL, ST_ADDR, ST_COLON, ST_GSP, ST_HEXH, ST_HEXL: tx_valid = 1'b1;
`ifdef MEM_HEXDUMP_ASCII_EN
            ST_ASP, ST_ACHR: tx_valid = 1'b1;
`endif
            default: tx_valid = 1'b0;
        endcase
    end

`ifdef MEM_HEXDUMP_ASCII_EN
    assign mem_rd = (state_q == ST_FETCH) || (state_q == ST_AFETCH);
`else
    assign mem_rd = (state_q == ST_FETCH);
`endif
    assign mem_a       = mem_rd ? byte_a : '0;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        rows_d  = rows_q;
        bidx_d  = bidx_q;
        didx_d  = didx_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d   = addr & ~ASZ'(ROW - 1);
                    rows_d  = nrows;
                    bidx_d  = '0;
                    didx_d  = '0;
                    state_d = (len == '0) ? ST_DONE : ST_NL;
                end
            end
            ST_NL: begin
                if (tx_ready) begin
                    didx_d  = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (tx_ready) begin
                    if (didx_q == DW'(ADW - 1)) state_d = ST_COLON;
                    else                        didx_d  = didx_q + 1'b1;
                end
            end
            ST_COLON: begin
                if (tx_ready) begin
                    bidx_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                byte_d  = mem_vo;
                state_d = grp_start ? ST_GSP : ST_HEXH;
            end
            ST_GSP:  if (tx_ready) state_d = ST_HEXH;
            ST_HEXH: if (tx_ready) state_d = ST_HEXL;
            ST_HEXL: begin
                if (tx_ready) begin
                    if (&bidx_q) begin
`ifdef MEM_HEXDUMP_ASCII_EN
                        didx_d  = '0;
                        state_d = ST_ASP;
`else
                        state_d = ST_NEXT;
`endif
                    end else begin
                        bidx_d  = bidx_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
`ifdef MEM_HEXDUMP_ASCII_EN
            // Second pass over the row re-reads each byte for the ASCII column.
            ST_ASP: begin
                if (tx_ready) begin
                    if (didx_q == DW'(1)) begin
                        bidx_d  = '0;
                        state_d = ST_AFETCH;
                    end else begin
                        didx_d  = didx_q + 1'b1;
                    end
                end
            end
            ST_AFETCH: state_d = ST_AWAIT;
            ST_AWAIT: begin
                byte_d  = mem_vo;
                state_d = ST_ACHR;
            end
            ST_ACHR: begin
                if (tx_ready) begin
                    if (&bidx_q) begin
                        state_d = ST_NEXT;
                    end else begin
                        bidx_d  = bidx_q + 1'b1;
                        state_d = ST_AFETCH;
                    end
                end
            end
`endif
            ST_NEXT: begin
                rows_d = rows_q - 1'b1;
                if (rows_q == RCW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + ASZ'(ROW);
                    state_d = ST_NL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            rows_q  <= '0;
            bidx_q  <= '0;
            didx_q  <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rows_q  <= rows_d;
            bidx_q  <= bidx_d;
            didx_q  <= didx_d;
            byte_q  <= byte_d;
        end
    end

    hexdump_fmt #(
        .ASZ(ASZ),
        .ADW(ADW),
        .DW (DW)
    ) u_fmt (
        .state_i  (state_q),
        .row_a_i  (row_q),
        .didx_i   (didx_q),
        .byte_i   (byte_q),
        .tx_data_o(tx_data)
    );

endmodule
